cpu_sram_bridge: RTL and testbench



---
 rtl/cpu_sram_bridge_pkg.sv | 42 ++++
 rtl/sram_bridge_port.sv | 40 ++++
 rtl/cpu_sram_bridge.sv | 170 +++++++++++++++++
 tb/tb_cpu_sram_bridge.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_sram_bridge_pkg.sv
// Shared constants, bus command payload and size helper for cpu_sram_bridge.
package cpu_sram_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned SIZE_W = 2;

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_ADDR = 2'd1,
    B_DATA = 2'd2
  } bus_state_e;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam logic [SIZE_W-1:0] SIZE_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SIZE_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_WORD = 2'd2;

  // Fields latched at grant time and held on the bus for the whole transaction
  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

  // Transfer size implied by the byte strobes; no strobes (a read) is a word
  function automatic logic [SIZE_W-1:0] size_from_wen(input logic [STRB_W-1:0] wen);
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return SIZE_BYTE;
      4'b0011, 4'b1100:                   return SIZE_HALF;
      default:                            return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/sram_bridge_port.sv
// Per-core-port bookkeeping: served flag, returned-word register, pending request.
module sram_bridge_port
  import cpu_sram_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              advance,
  input  logic              complete,
  input  logic              capture,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              pending_c,
  output logic [DATA_W-1:0] rdata
);

  logic done;

  assign pending_c = en & ~done;

  // Served flag: set by this port's response, dropped once the pipeline advances
  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
    end else if (complete) begin
      done <= 1'b1;
    end else if (advance) begin
      done <= 1'b0;
    end
  end

  // Returned word, held until this port's next read response
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (capture) begin
      rdata <= bus_rdata;
    end
  end

endmodule

// File: rtl/cpu_sram_bridge.sv
// Bridges the core's inst/data SRAM ports onto one req/addr_ok/data_ok bus.
// Optional build macro: SRAM_BRIDGE_IFETCH_REUSE_EN (single-entry fetch reuse).
module cpu_sram_bridge
  import cpu_sram_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst,

  input  logic              inst_sram_en,
  input  logic [STRB_W-1:0] inst_sram_wen,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [DATA_W-1:0] inst_sram_wdata,
  output logic [DATA_W-1:0] inst_sram_rdata,

  input  logic              data_sram_en,
  input  logic [STRB_W-1:0] data_sram_wen,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic [DATA_W-1:0] data_sram_rdata,

  output logic              stallreq_for_bus,

  output logic              bus_req,
  output logic              bus_wr,
  output logic [SIZE_W-1:0] bus_size,
  output logic [STRB_W-1:0] bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  bus_state_e state;
  owner_e     owner;
  bus_cmd_t   cmd_q;
  bus_cmd_t   inst_cmd;
  bus_cmd_t   data_cmd;

  logic inst_pending;
  logic data_pending;
  logic inst_hit;
  logic inst_en_eff;
  logic advance;
  logic data_inflight;
  logic inst_complete;
  logic data_complete;
  logic unused_inst_bits;

  // The instruction port is read-only; its write inputs carry nothing
  assign unused_inst_bits = ^{inst_sram_wen, inst_sram_wdata};

  assign stallreq_for_bus = ~rst & (inst_pending | data_pending);
  assign advance          = ~stallreq_for_bus;
  assign data_inflight    = (state != B_IDLE) && (owner == OWNER_DATA);
  assign inst_complete    = (state == B_DATA) && bus_data_ok && (owner == OWNER_INST);
  assign data_complete    = (state == B_DATA) && bus_data_ok && (owner == OWNER_DATA);
  assign inst_en_eff      = inst_sram_en & ~inst_hit;

  // Candidate bus commands for each port
  always_comb begin
    inst_cmd       = '0;
    inst_cmd.size  = SIZE_WORD;
    inst_cmd.addr  = inst_sram_addr;

    data_cmd       = '0;
    data_cmd.wr    = |data_sram_wen;
    data_cmd.size  = size_from_wen(data_sram_wen);
    data_cmd.wstrb = data_sram_wen;
    data_cmd.addr  = data_sram_addr;
    data_cmd.wdata = data_sram_wdata;
  end

`ifdef SRAM_BRIDGE_IFETCH_REUSE_EN
  logic              reuse_valid;
  logic [ADDR_W-1:0] last_iaddr;
  logic              store_hits_fetch;

  assign inst_hit         = reuse_valid && (inst_sram_addr == last_iaddr);
  assign store_hits_fetch = (state == B_IDLE) && data_pending && !data_inflight && data_cmd.wr &&
                            (data_sram_addr[ADDR_W-1:2] == last_iaddr[ADDR_W-1:2]);

  // Remember the last fetched address; a store to that word invalidates it
  always_ff @(posedge clk) begin
    if (rst) begin
      reuse_valid <= 1'b0;
      last_iaddr  <= '0;
    end else if (inst_complete) begin
      reuse_valid <= 1'b1;
      last_iaddr  <= cmd_q.addr;
    end else if (store_hits_fetch) begin
      reuse_valid <= 1'b0;
    end
  end
`else
  assign inst_hit = 1'b0;
`endif

  sram_bridge_port u_inst_port (
    .clk       (clk),
    .rst       (rst),
    .en        (inst_en_eff),
    .advance   (advance),
    .complete  (inst_complete),
    .capture   (inst_complete),
    .bus_rdata (bus_rdata),
    .pending_c (inst_pending),
    .rdata     (inst_sram_rdata)
  );

  sram_bridge_port u_data_port (
    .clk       (clk),
    .rst       (rst),
    .en        (data_sram_en),
    .advance   (advance),
    .complete  (data_complete),
    .capture   (data_complete & ~cmd_q.wr),
    .bus_rdata (bus_rdata),
    .pending_c (data_pending),
    .rdata     (data_sram_rdata)
  );

  // Bus FSM: grant (data first), hold the request until addr_ok, wait for data_ok
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= B_IDLE;
      owner   <= OWNER_INST;
      cmd_q   <= '0;
      bus_req <= 1'b0;
    end else begin
      case (state)
        B_IDLE: begin
          if (data_pending && !data_inflight) begin
            owner   <= OWNER_DATA;
            cmd_q   <= data_cmd;
            bus_req <= 1'b1;
            state   <= B_ADDR;
          end else if (inst_pending) begin
            owner   <= OWNER_INST;
            cmd_q   <= inst_cmd;
            bus_req <= 1'b1;
            state   <= B_ADDR;
          end
        end
        B_ADDR: begin
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            state   <= B_DATA;
          end
        end
        B_DATA: begin
          if (bus_data_ok) begin
            state <= B_IDLE;
          end
        end
        default: begin
          bus_req <= 1'b0;
          state   <= B_IDLE;
        end
      endcase
    end
  end

  assign bus_wr    = cmd_q.wr;
  assign bus_size  = cmd_q.size;
  assign bus_wstrb = cmd_q.wstrb;
  assign bus_addr  = cmd_q.addr;
  assign bus_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_cpu_sram_bridge.sv
// Self-checking bench for cpu_sram_bridge: directed scenarios plus randomized
// request mixes against a transaction-level model and a reactive bus slave.
module tb_cpu_sram_bridge;

`ifdef SRAM_BRIDGE_IFETCH_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stallreq_for_bus;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  cpu_sram_bridge dut (
    .clk              (clk),
    .rst              (rst),
    .inst_sram_en     (inst_sram_en),
    .inst_sram_wen    (inst_sram_wen),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_wdata  (inst_sram_wdata),
    .inst_sram_rdata  (inst_sram_rdata),
    .data_sram_en     (data_sram_en),
    .data_sram_wen    (data_sram_wen),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .data_sram_rdata  (data_sram_rdata),
    .stallreq_for_bus (stallreq_for_bus),
    .bus_req          (bus_req),
    .bus_wr           (bus_wr),
    .bus_size         (bus_size),
    .bus_wstrb        (bus_wstrb),
    .bus_addr         (bus_addr),
    .bus_wdata        (bus_wdata),
    .bus_addr_ok      (bus_addr_ok),
    .bus_data_ok      (bus_data_ok),
    .bus_rdata        (bus_rdata)
  );

  always #5 clk = ~clk;

  // One expected bus transaction, with the slave's chosen delays and response
  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          a;
    int          d;
    logic [31:0] resp;
  } txn_t;

  int          checks = 0;
  int          errors = 0;
  txn_t        exp_q[$];
  logic [31:0] exp_irdata = '0;
  logic [31:0] exp_drdata = '0;
  logic        model_valid = 1'b0;
  logic [31:0] model_iaddr = '0;
  logic [3:0]  wen_tab [9] = '{4'h0, 4'h0, 4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  function automatic int pick_dly(input int fix);
    return (fix < 0) ? int'($urandom_range(0, 3)) : fix;
  endfunction

  task automatic chk_bus_reset(input string tag);
    chk({tag, "_req"},   32'(bus_req),   32'd0);
    chk({tag, "_wr"},    32'(bus_wr),    32'd0);
    chk({tag, "_size"},  32'(bus_size),  32'd0);
    chk({tag, "_wstrb"}, 32'(bus_wstrb), 32'd0);
    chk({tag, "_addr"},  bus_addr,       32'd0);
    chk({tag, "_wdata"}, bus_wdata,      32'd0);
  endtask

  // Apply one core request set, play the slave, and check the whole episode
  task automatic run_req(input logic ien, input logic [31:0] iaddr, input logic [31:0] iresp,
                         input logic den, input logic [3:0] wen, input logic [31:0] daddr,
                         input logic [31:0] dwdata, input logic [31:0] dresp,
                         input int a_fix, input int d_fix);
    txn_t        t;
    txn_t        cur;
    int          exp_stall = 0;
    int          stall_cnt = 0;
    int          phase = 0;
    int          cnt = 0;
    bit          finished = 1'b0;
    logic [70:0] snap = '0;

    // Model: data is served before inst; each access costs 3 + wait cycles
    exp_q.delete();
    if (den) begin
      t.wr    = (wen != 4'b0000);
      t.wstrb = wen;
      case ($countones(wen))
        1:       t.size = 2'd0;
        2:       t.size = 2'd1;
        default: t.size = 2'd2;
      endcase
      t.addr  = daddr;
      t.wdata = dwdata;
      t.a     = pick_dly(a_fix);
      t.d     = pick_dly(d_fix);
      t.resp  = dresp;
      exp_q.push_back(t);
      exp_stall += 3 + t.a + t.d;
      if (t.wr) begin
        if (daddr[31:2] == model_iaddr[31:2]) model_valid = 1'b0;
      end else begin
        exp_drdata = dresp;
      end
    end
    if (ien && !(REUSE && model_valid && (iaddr == model_iaddr))) begin
      t.wr    = 1'b0;
      t.wstrb = 4'b0000;
      t.size  = 2'd2;
      t.addr  = iaddr;
      t.wdata = '0;
      t.a     = pick_dly(a_fix);
      t.d     = pick_dly(d_fix);
      t.resp  = iresp;
      exp_q.push_back(t);
      exp_stall  += 3 + t.a + t.d;
      exp_irdata  = iresp;
      model_valid = 1'b1;
      model_iaddr = iaddr;
    end

    @(posedge clk); #1;
    inst_sram_en    = ien;
    inst_sram_addr  = iaddr;
    inst_sram_wen   = 4'($urandom);
    inst_sram_wdata = $urandom;
    data_sram_en    = den;
    data_sram_wen   = wen;
    data_sram_addr  = daddr;
    data_sram_wdata = dwdata;

    for (int c = 0; c < 200 && !finished; c++) begin
      @(negedge clk);
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b0;
      bus_rdata   = $urandom;
      if (!stallreq_for_bus) begin
        finished = 1'b1;
      end else begin
        stall_cnt++;
        if (bus_req) begin
          if (phase == 0) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_req", 32'(bus_req), 32'd0);
            end else begin
              cur   = exp_q.pop_front();
              phase = 1;
              cnt   = 0;
              snap  = {bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata};
              chk("req_wr",    32'(bus_wr),    32'(cur.wr));
              chk("req_addr",  bus_addr,       cur.addr);
              chk("req_size",  32'(bus_size),  32'(cur.size));
              chk("req_wstrb", 32'(bus_wstrb), 32'(cur.wstrb));
              if (cur.wr) chk("req_wdata", bus_wdata, cur.wdata);
            end
          end else begin
            chk("req_stable", 32'({bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata} !== snap), 32'd0);
          end
          if (phase == 1) begin
            if (cnt == cur.a) begin
              bus_addr_ok = 1'b1;
              phase       = 2;
              cnt         = 0;
            end else begin
              cnt++;
            end
          end
        end else if (phase == 2) begin
          if (cnt == cur.d) begin
            bus_data_ok = 1'b1;
            bus_rdata   = cur.resp;
            phase       = 0;
          end else begin
            cnt++;
          end
        end
      end
    end

    if (!finished) chk("stall_timeout", 32'(stallreq_for_bus), 32'd0);
    chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
    chk("txns_left",    32'(exp_q.size()), 32'd0);
    chk("bus_req_idle", 32'(bus_req), 32'd0);
    chk("inst_rdata",   inst_sram_rdata, exp_irdata);
    chk("data_rdata",   data_sram_rdata, exp_drdata);

    // Cycle after the advance: the core drops its requests and samples the words
    @(posedge clk); #1;
    inst_sram_en = 1'b0;
    data_sram_en = 1'b0;
    @(negedge clk);
    chk("inst_rdata_hold", inst_sram_rdata, exp_irdata);
    chk("data_rdata_hold", data_sram_rdata, exp_drdata);
    chk("idle_stall",      32'(stallreq_for_bus), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    inst_sram_en    = 1'b1;
    inst_sram_wen   = 4'h0;
    inst_sram_addr  = 32'hBFC00000;
    inst_sram_wdata = '0;
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'h0;
    data_sram_addr  = 32'h80000000;
    data_sram_wdata = '0;
    bus_addr_ok     = 1'b0;
    bus_data_ok     = 1'b0;
    bus_rdata       = '0;

    // Reset values, with requests present to show the stall is forced low
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_bus_reset("rst");
    chk("rst_stall",      32'(stallreq_for_bus), 32'd0);
    chk("rst_inst_rdata", inst_sram_rdata, 32'd0);
    chk("rst_data_rdata", data_sram_rdata, 32'd0);
    @(posedge clk); #1;
    rst          = 1'b0;
    inst_sram_en = 1'b0;
    data_sram_en = 1'b0;

    // Single fetch, fastest slave
    run_req(1'b1, 32'hBFC00000, 32'h3C080001, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 0);

    // Fetch and load in the same cycle
    run_req(1'b1, 32'hBFC00004, 32'h24090002, 1'b1, 4'h0, 32'h80000010, 32'h0, 32'h12345678, -1, -1);

    // Byte store leaves the load word untouched
    run_req(1'b0, 32'h0, 32'h0, 1'b1, 4'b0100, 32'h80000020, 32'h00AB0000, 32'hFFFFFFFF, -1, -1);

    // Backpressure: addr_ok withheld for five cycles
    run_req(1'b1, 32'hBFC00020, 32'hA5A55A5A, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 5, 1);
    run_req(1'b0, 32'h0, 32'h0, 1'b1, 4'b1100, 32'h80000040, 32'hCAFE0000, 32'h0, 5, 0);

    // Reset while the bus waits for data_ok, then a stale data_ok
    @(posedge clk); #1;
    inst_sram_en   = 1'b1;
    inst_sram_addr = 32'hBFC00010;
    @(negedge clk);
    @(negedge clk);
    chk("rmt_req", 32'(bus_req), 32'd1);
    bus_addr_ok = 1'b1;
    @(negedge clk);
    bus_addr_ok  = 1'b0;
    rst          = 1'b1;
    inst_sram_en = 1'b0;
    @(negedge clk);
    chk_bus_reset("rmt");
    chk("rmt_stall", 32'(stallreq_for_bus), 32'd0);
    rst         = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = 32'hDEADBEEF;
    @(negedge clk);
    bus_data_ok = 1'b0;
    chk("rmt_inst_rdata", inst_sram_rdata, 32'd0);
    chk("rmt_data_rdata", data_sram_rdata, 32'd0);
    chk("rmt_req_after",  32'(bus_req), 32'd0);
    model_valid = 1'b0;
    exp_irdata  = '0;
    exp_drdata  = '0;

    // A fresh fetch must stall fully (no served flag survived the reset)
    run_req(1'b1, 32'hBFC00008, 32'h11112222, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, -1, -1);
    // Repeat fetch: reused when the feature is built in, else a normal access
    run_req(1'b1, 32'hBFC00008, 32'h33334444, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, -1, -1);
    // Store to the fetched word, then the fetch must go to the bus again
    run_req(1'b0, 32'h0, 32'h0, 1'b1, 4'hF, 32'hBFC00008, 32'h55556666, 32'h0, -1, -1);
    run_req(1'b1, 32'hBFC00008, 32'h77778888, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, -1, -1);

    // Randomized request mixes
    for (int i = 0; i < 40; i++) begin
      logic        ien;
      logic        den;
      logic [3:0]  wen;
      logic [31:0] iaddr;
      logic [31:0] daddr;
      ien   = 1'($urandom_range(0, 1));
      den   = 1'($urandom_range(0, 1));
      wen   = wen_tab[$urandom_range(0, 8)];
      iaddr = 32'hBFC00000 + 32'(4 * $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) daddr = 32'hBFC00000 + 32'($urandom_range(0, 15));
      else                           daddr = 32'h80000000 | ($urandom & 32'h0000FFFC);
      run_req(ien, iaddr, $urandom, den, wen, daddr, $urandom, $urandom, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
